// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, return-PC assembly.
// Optional hardware-interrupt injection is enabled by defining INTERRUPT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        fetch_pc_enable,
    input  logic        flush_fetch,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc_jmp,
    input  logic [15:0] pop_pc_data,
    input  logic        pop_pc1,
    input  logic        pop_pc2,
    input  logic        rti,
    input  logic        interrupt,
    output logic [15:0] instruction,
    output logic [31:0] if_pc,
    output logic        int_ack
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC   = 32'h0000_0020;
    localparam logic [PC_W-1:0]    INT_VECTOR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] INT_OPCODE = 16'hF800;
    localparam logic [INSTR_W-1:0] NOP        = 16'h0000;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_JMP  = 2'b01;
    localparam logic [1:0] SEL_POP  = 2'b10;

    typedef enum logic {
        RUN         = 1'b0,
        INT_SERVICE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]   pop_hi_q, pop_hi_d;
    logic [INSTR_W-1:0]   pop_lo_q, pop_lo_d;
    logic                 pending_q, pending_d;
    logic                 int_ack_q, int_ack_d;

    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      pop_target;
    logic                 take_int;

    // State register and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            if_pc_q   <= '0;
            pop_hi_q  <= '0;
            pop_lo_q  <= '0;
            pending_q <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            if_pc_q   <= if_pc_d;
            pop_hi_q  <= pop_hi_d;
            pop_lo_q  <= pop_lo_d;
            pending_q <= pending_d;
            int_ack_q <= int_ack_d;
        end
    end

    // Next-state: interrupt FSM, PC select, IF/ID update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        pop_hi_d   = pop_hi_q;
        pop_lo_d   = pop_lo_q;
        pending_d  = pending_q;
        int_ack_d  = 1'b0;
        take_int   = 1'b0;
        pc_inc     = pc_q + PC_W'(1);
        // Low half bypasses the stack register when it arrives with the redirect
        pop_target = {pop_hi_q, (pop_pc2 ? pop_pc_data : pop_lo_q)};

`ifdef INTERRUPT_EN
        // A live request may be taken in the same cycle it arrives
        case (state_q)
            RUN: begin
                if ((pending_q || interrupt) && fetch_pc_enable && !flush_fetch
                    && (pc_sel == SEL_SEQ)) begin
                    take_int  = 1'b1;
                    pending_d = 1'b0;
                    state_d   = INT_SERVICE;
                end else if (interrupt) begin
                    pending_d = 1'b1;
                end
            end
            INT_SERVICE: begin
                if (rti) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
`endif

        if (pop_pc1) begin
            pop_hi_d = pop_pc_data;
        end
        if (pop_pc2) begin
            pop_lo_d = pop_pc_data;
        end

        case (pc_sel)
            SEL_JMP: pc_d = pc_jmp;
            SEL_POP: pc_d = pop_target;
            SEL_SEQ: begin
                if (take_int) begin
                    pc_d = INT_VECTOR;
                end else if (fetch_pc_enable) begin
                    pc_d = pc_inc;
                end
            end
            default: pc_d = pc_q;
        endcase

        if (flush_fetch) begin
            instr_d = NOP;
            if_pc_d = '0;
        end else if (!fetch_pc_enable) begin
            instr_d = instr_q;
            if_pc_d = if_pc_q;
        end else if (take_int) begin
            // Unfetched PC becomes the return address
            instr_d = INT_OPCODE;
            if_pc_d = pc_q;
        end else begin
            instr_d = imem_data;
            if_pc_d = pc_inc;
        end

        int_ack_d = take_int;
    end

`ifndef INTERRUPT_EN
    logic unused_int_c;
    assign unused_int_c = interrupt ^ rti;
`endif

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign if_pc       = if_pc_q;
    assign int_ack     = int_ack_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; interrupt steps follow INTERRUPT_EN.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        fetch_pc_enable;
    logic        flush_fetch;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jmp;
    logic [15:0] pop_pc_data;
    logic        pop_pc1;
    logic        pop_pc2;
    logic        rti;
    logic        interrupt;
    logic [15:0] instruction;
    logic [31:0] if_pc;
    logic        int_ack;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .fetch_pc_enable (fetch_pc_enable),
        .flush_fetch     (flush_fetch),
        .pc_sel          (pc_sel),
        .pc_jmp          (pc_jmp),
        .pop_pc_data     (pop_pc_data),
        .pop_pc1         (pop_pc1),
        .pop_pc2         (pop_pc2),
        .rti             (rti),
        .interrupt       (interrupt),
        .instruction     (instruction),
        .if_pc           (if_pc),
        .int_ack         (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: two fixed words, elsewhere 16'hC000 | addr[11:0]
    always_comb begin
        case (imem_addr)
            32'h0000_0020: imem_data = 16'h1234;
            32'h0000_0021: imem_data = 16'h5678;
            default:       imem_data = 16'hC000 | {4'h0, imem_addr[11:0]};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr,
                            input logic [15:0] ins, input logic [31:0] pc);
        check({tag, "_addr"},  addr, imem_addr);
        check({tag, "_instr"}, 32'(instruction), 32'(ins));
        check({tag, "_ifpc"},  if_pc, pc);
    endtask

    initial begin
        rst = 1'b1; fetch_pc_enable = 1'b1; flush_fetch = 1'b0; pc_sel = 2'b00;
        pc_jmp = '0; pop_pc_data = '0; pop_pc1 = 1'b0; pop_pc2 = 1'b0;
        rti = 1'b0; interrupt = 1'b0;

        // Reset
        step();
        check("rst_addr", imem_addr, 32'h20);
        check("rst_instr", 32'(instruction), 32'h0);
        check("rst_ifpc", if_pc, 32'h0);
        check("rst_ack", 32'(int_ack), 32'h0);
        step();
        rst = 1'b0;

        // Sequential fetch
        step(); check_if("seq1", 32'h21, 16'h1234, 32'h21);
        step(); check_if("seq2", 32'h22, 16'h5678, 32'h22);

        // Stall three cycles
        fetch_pc_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_if("stall", 32'h22, 16'h5678, 32'h22);
        end

        // Flush
        fetch_pc_enable = 1'b1; flush_fetch = 1'b1;
        step(); check_if("flush", 32'h23, 16'h0000, 32'h0);
        flush_fetch = 1'b0;

        // Branch during stall
        fetch_pc_enable = 1'b0; pc_sel = 2'b01; pc_jmp = 32'h100;
        step(); check_if("brstall", 32'h100, 16'h0000, 32'h0);
        fetch_pc_enable = 1'b1; pc_sel = 2'b00;
        step(); check_if("brseq", 32'h101, 16'hC100, 32'h101);

        // pc_sel=11 holds PC but IF/ID still loads
        pc_sel = 2'b11;
        step(); check_if("hold", 32'h101, 16'hC101, 32'h102);

        // Two-cycle pop with bypass
        pc_sel = 2'b00; pop_pc1 = 1'b1; pop_pc_data = 16'h0001;
        step(); check_if("pop1", 32'h102, 16'hC101, 32'h102);
        pop_pc1 = 1'b0; pop_pc2 = 1'b1; pop_pc_data = 16'h0040; pc_sel = 2'b10;
        step(); check_if("popbyp", 32'h0001_0040, 16'hC102, 32'h103);
        // Stored halves used without bypass
        pop_pc2 = 1'b0; pop_pc_data = 16'hBEEF;
        step(); check("popreg_addr", imem_addr, 32'h0001_0040);

        // Move to PC=0x30
        pc_sel = 2'b01; pc_jmp = 32'h30;
        step(); check("jmp30_addr", imem_addr, 32'h30);
        pc_sel = 2'b00;

`ifdef INTERRUPT_EN
        interrupt = 1'b1;
        step(); check_if("int1", 32'h0, 16'hF800, 32'h30);
        check("int1_ack", 32'(int_ack), 32'h1);
        step(); check_if("isr1", 32'h1, 16'hC000, 32'h1);
        check("isr1_ack", 32'(int_ack), 32'h0);
        step(); check("isr2_addr", imem_addr, 32'h2);
        check("isr2_ack", 32'(int_ack), 32'h0);
        interrupt = 1'b0; rti = 1'b1;
        step(); check("rti_addr", imem_addr, 32'h3);
        rti = 1'b0; interrupt = 1'b1;
        step(); check_if("int2", 32'h0, 16'hF800, 32'h3);
        check("int2_ack", 32'(int_ack), 32'h1);
        interrupt = 1'b0; rti = 1'b1;
        step(); check("rti2_addr", imem_addr, 32'h1);
        rti = 1'b0;
        // Interrupt pulse during stall is remembered
        fetch_pc_enable = 1'b0; interrupt = 1'b1;
        step(); check("pend_addr", imem_addr, 32'h1);
        check("pend_ack", 32'(int_ack), 32'h0);
        fetch_pc_enable = 1'b1; interrupt = 1'b0;
        step(); check_if("int3", 32'h0, 16'hF800, 32'h1);
        check("int3_ack", 32'(int_ack), 32'h1);
        rti = 1'b1;
        step(); check("rti3_addr", imem_addr, 32'h1);
        rti = 1'b0;
`else
        interrupt = 1'b1;
        step(); check_if("noint", 32'h31, 16'hC030, 32'h31);
        check("noint_ack", 32'(int_ack), 32'h0);
        rti = 1'b1;
        step(); check("noint2_ack", 32'(int_ack), 32'h0);
        check("noint2_addr", imem_addr, 32'h32);
        interrupt = 1'b0; rti = 1'b0;
`endif

        // Reset beats a simultaneous redirect
        rst = 1'b1; pc_sel = 2'b01; pc_jmp = 32'h500;
        step(); check_if("rstredir", 32'h20, 16'h0000, 32'h0);
        check("rstredir_ack", 32'(int_ack), 32'h0);
        rst = 1'b0;

        // Wrap-around
        pc_jmp = 32'hFFFF_FFFF;
        step(); check("wrap_jmp", imem_addr, 32'hFFFF_FFFF);
        pc_sel = 2'b00;
        step(); check_if("wrap", 32'h0, 16'hCFFF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
